// File: rtl/cv32e40p_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_pkg
// Purpose  : Shared types and constants for the fetch aligner.
//            - aligner_state_e : alignment state of the instruction stream
//            - OPCODE_C_MASK   : low-bit pattern that marks a 32-bit opcode
// Revision : 1.0 - initial release
// ============================================================================
package cv32e40p_pkg;

    // ALIGNED           : pc[1]=0, nothing buffered
    // MISALIGNED        : residue holds the halfword located at pc
    // BRANCH_MISALIGNED : branch target has pc[1]=1, lower half of the
    //                     first fetched word is not part of the stream
    typedef enum logic [1:0] {
        ALIGNED           = 2'd0,
        MISALIGNED        = 2'd1,
        BRANCH_MISALIGNED = 2'd2
    } aligner_state_e;

    // Instructions whose two LSBs equal this pattern are 32-bit; anything
    // else is a 16-bit compressed instruction.
    localparam logic [1:0] OPCODE_C_MASK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_fetch_aligner
// Purpose  : Turns the word-aligned fetch stream from the prefetch buffer
//            into one complete, halfword-aligned instruction per ID
//            handshake. Compressed instructions are zero-extended, 32-bit
//            instructions crossing a word boundary are stitched from a
//            buffered upper halfword (residue) and the next fetch word.
// Ports    :
//   clk                 in   core clock
//   rst_n               in   asynchronous active-low reset
//   fetch_valid_i       in   prefetch word valid
//   fetch_ready_o       out  fetch word is popped this cycle
//   fetch_rdata_i[31:0] in   fetch word, [15:0] is the lower address
//   id_ready_i          in   ID stage accepts the instruction
//   instr_valid_o       out  complete instruction available
//   instr_aligned_o     out  instruction ({16'h0, c} when compressed)
//   instr_compressed_o  out  instruction is 16-bit
//   pc_o[31:0]          out  address of instr_aligned_o
//   branch_i            in   redirect request
//   branch_addr_i[31:0] in   redirect target (bit 0 always 0)
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_fetch_aligner
    import cv32e40p_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,

    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_aligned_o,
    output logic        instr_compressed_o,
    output logic [31:0] pc_o,

    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic is_compressed(input logic [15:0] half);
        return (half[1:0] != OPCODE_C_MASK);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    aligner_state_e state_q, state_d;
    logic [15:0]    residue_q, residue_d;
    logic [31:0]    pc_q, pc_d;

    // Ungated instruction-side results of the alignment mux
    logic           instr_valid;
    logic           fetch_ready;
    logic [31:0]    instr;
    logic           instr_comp;
    logic           hs;

    logic [15:0]    w_lo;
    logic [15:0]    w_hi;

    assign w_lo = fetch_rdata_i[15:0];
    assign w_hi = fetch_rdata_i[31:16];

    // ------------------------------------------------------------------
    // Alignment mux: what instruction sits at pc and whether the current
    // fetch word is needed to complete it.
    // ------------------------------------------------------------------
    always_comb begin
        instr_valid = 1'b0;
        fetch_ready = 1'b0;
        instr       = 32'h0;
        instr_comp  = 1'b0;

        case (state_q)
            ALIGNED: begin
                instr_valid = fetch_valid_i;
                fetch_ready = id_ready_i;
                if (is_compressed(w_lo)) begin
                    instr      = {16'h0, w_lo};
                    instr_comp = 1'b1;
                end else begin
                    instr      = fetch_rdata_i;
                    instr_comp = 1'b0;
                end
            end

            MISALIGNED: begin
                if (is_compressed(residue_q)) begin
                    // Buffered halfword is a whole instruction on its own;
                    // the fetch word stays in the prefetch buffer.
                    instr_valid = 1'b1;
                    fetch_ready = 1'b0;
                    instr       = {16'h0, residue_q};
                    instr_comp  = 1'b1;
                end else begin
                    // Straddling 32-bit instruction: upper half comes from
                    // the lower half of the next fetch word.
                    instr_valid = fetch_valid_i;
                    fetch_ready = id_ready_i;
                    instr       = {w_lo, residue_q};
                    instr_comp  = 1'b0;
                end
            end

            BRANCH_MISALIGNED: begin
                if (is_compressed(w_hi)) begin
                    instr_valid = fetch_valid_i;
                    fetch_ready = id_ready_i;
                    instr       = {16'h0, w_hi};
                    instr_comp  = 1'b1;
                end else begin
                    // Only the first half of a 32-bit instruction is in
                    // this word: pop it into the residue without emitting.
                    instr_valid = 1'b0;
                    fetch_ready = fetch_valid_i;
                    instr       = 32'h0;
                    instr_comp  = 1'b0;
                end
            end

            default: begin
                instr_valid = 1'b0;
                fetch_ready = 1'b0;
                instr       = 32'h0;
                instr_comp  = 1'b0;
            end
        endcase
    end

    assign hs = instr_valid && id_ready_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        residue_d = residue_q;
        pc_d      = pc_q;

        if (branch_i) begin
            // Redirect wins over any handshake or pop in the same cycle
            pc_d      = branch_addr_i;
            residue_d = 16'h0;
            state_d   = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED;
        end else begin
            case (state_q)
                ALIGNED: begin
                    if (hs) begin
                        if (is_compressed(w_lo)) begin
                            residue_d = w_hi;
                            state_d   = MISALIGNED;
                            pc_d      = pc_q + 32'd2;
                        end else begin
                            state_d   = ALIGNED;
                            pc_d      = pc_q + 32'd4;
                        end
                    end
                end

                MISALIGNED: begin
                    if (hs) begin
                        if (is_compressed(residue_q)) begin
                            state_d   = ALIGNED;
                            pc_d      = pc_q + 32'd2;
                        end else begin
                            residue_d = w_hi;
                            state_d   = MISALIGNED;
                            pc_d      = pc_q + 32'd4;
                        end
                    end
                end

                BRANCH_MISALIGNED: begin
                    if (is_compressed(w_hi)) begin
                        if (hs) begin
                            state_d = ALIGNED;
                            pc_d    = pc_q + 32'd2;
                        end
                    end else if (fetch_valid_i) begin
                        // Silent pop: pc still points at the buffered half
                        residue_d = w_hi;
                        state_d   = MISALIGNED;
                    end
                end

                default: begin
                    state_d = ALIGNED;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ALIGNED;
            residue_q <= 16'h0;
            pc_q      <= 32'h0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
            pc_q      <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Reset is folded in combinationally so handshakes drop in
    // the very cycle reset asserts, not only after the registers clear.
    // ------------------------------------------------------------------
    assign instr_valid_o      = rst_n && !branch_i && instr_valid;
    assign fetch_ready_o      = rst_n && !branch_i && fetch_ready;
    assign instr_aligned_o    = rst_n ? instr : 32'h0;
    assign instr_compressed_o = rst_n && instr_comp;
    assign pc_o               = rst_n ? pc_q : 32'h0;

endmodule
`default_nettype wire
